// File: rtl/mire_fb_writer_if.sv
// Wishbone classic bus bundle between the framebuffer pattern writer and the SDRAM arbiter.
interface mire_fb_writer_if;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        stb;
  logic        cyc;
  logic        ack;

  modport master (
    output adr, dat_ms, we, sel, cti, bte, stb, cyc,
    input  ack, dat_sm
  );

  modport slave (
    input  adr, dat_ms, we, sel, cti, bte, stb, cyc,
    output ack, dat_sm
  );
endinterface

// File: rtl/mire_fb_writer.sv
// Wishbone master that fills a linear 32-bit-per-pixel framebuffer with a grid test pattern,
// releasing cyc for one cycle after every BURST_LEN accepted writes.
module mire_fb_writer #(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter int unsigned GRID      = 16,
  parameter int unsigned BURST_LEN = 64,
  parameter logic [31:0] FG_COLOR  = 32'h00FFFFFF,
  parameter logic [31:0] BG_COLOR  = 32'h00000000
) (
  input  logic             wshb_clk,
  input  logic             wshb_rst,
  input  logic             enable,
  mire_fb_writer_if.master wb,
  output logic             frame_done
);

  localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    PAUSE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [BW-1:0]   burst_cnt;
  logic            accept;
  logic            x_last;
  logic            y_last;
  logic            burst_last;
  logic [31:0]     pix;
  logic            on_grid;
  logic            unused_ok;

  assign x_last     = (x == XW'(HDISP - 1));
  assign y_last     = (y == YW'(VDISP - 1));
  assign burst_last = (burst_cnt == BW'(BURST_LEN - 1));
  assign accept     = (state == WRITE) && wb.ack;

  assign wb.we  = 1'b1;
  assign wb.sel = 4'b1111;
  assign wb.cti = 3'b000;
  assign wb.bte = 2'b00;

  // Read data is never consumed by a write-only master.
  assign unused_ok = ^wb.dat_sm;

  assign pix    = 32'(x) + 32'(y) * HDISP;
  assign wb.adr = pix << 2;

  assign on_grid   = ((32'(x) & (GRID - 1)) == 32'd0) || ((32'(y) & (GRID - 1)) == 32'd0);
  assign wb.dat_ms = on_grid ? FG_COLOR : BG_COLOR;

  always_ff @(posedge wshb_clk) begin
    if (wshb_rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      burst_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
        burst_cnt <= burst_last ? '0 : burst_cnt + 1'b1;
      end
    end
  end

  // Burst end takes priority over enable: the PAUSE cycle decides between WRITE and IDLE.
  always_comb begin
    state_next = state;
    wb.stb     = 1'b0;
    wb.cyc     = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = WRITE;
      end
      WRITE: begin
        wb.stb = 1'b1;
        wb.cyc = 1'b1;
        if (wb.ack) begin
          frame_done = x_last && y_last;
          if (burst_last)   state_next = PAUSE;
          else if (!enable) state_next = IDLE;
        end
      end
      PAUSE: begin
        state_next = enable ? WRITE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mire_fb_writer.sv
// Scoreboard bench for mire_fb_writer: a pixel-index reference model queues expected writes,
// a negedge monitor checks every accepted transfer plus bus-protocol timing.
module tb_mire_fb_writer;
  localparam int unsigned HDISP     = 40;
  localparam int unsigned VDISP     = 10;
  localparam int unsigned GRID      = 8;
  localparam int unsigned BURST_LEN = 16;
  localparam logic [31:0] FG        = 32'h00FFFFFF;
  localparam logic [31:0] BG        = 32'h00102030;
  localparam int unsigned NPIX      = HDISP * VDISP;

  logic wshb_clk = 1'b0;
  logic wshb_rst = 1'b1;
  logic enable   = 1'b0;
  logic frame_done;

  mire_fb_writer_if wb();

  mire_fb_writer #(
    .HDISP(HDISP), .VDISP(VDISP), .GRID(GRID), .BURST_LEN(BURST_LEN),
    .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .wshb_clk  (wshb_clk),
    .wshb_rst  (wshb_rst),
    .enable    (enable),
    .wb        (wb.master),
    .frame_done(frame_done)
  );

  always #5 wshb_clk = ~wshb_clk;

  assign wb.dat_sm = 32'hDEADBEEF;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        fd;
  } exp_t;

  exp_t        expq[$];
  int unsigned next_pix  = 0;
  int unsigned n_checks  = 0;
  int unsigned n_pass    = 0;
  int unsigned n_acc     = 0;
  int unsigned n_pushed  = 0;
  int unsigned n_dropped = 0;
  int unsigned ack_mode  = 0;
  int unsigned cyc_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
  endtask

  // Reference model: pixels are visited in raster order, address = index*4.
  task automatic push_expect(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      exp_t e;
      int unsigned px;
      int unsigned py;
      px    = next_pix % HDISP;
      py    = next_pix / HDISP;
      e.adr = next_pix * 4;
      e.dat = ((px % GRID) == 0 || (py % GRID) == 0) ? FG : BG;
      e.fd  = (next_pix == NPIX - 1);
      expq.push_back(e);
      n_pushed++;
      next_pix = (next_pix + 1) % NPIX;
    end
  endtask

  task automatic wait_drain(input string name, input int unsigned limit);
    int unsigned n;
    n = 0;
    while (expq.size() != 0 && n < limit) begin
      @(posedge wshb_clk); #1;
      n++;
    end
    n_checks++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL %s: got %0d writes outstanding after %0d cycles, required 0", name, expq.size(), n);
  endtask

  // Slave: ack pattern by mode, only while the model still expects writes.
  initial begin
    wb.ack = 1'b0;
    forever begin
      logic a;
      @(posedge wshb_clk); #2;
      cyc_cnt++;
      case (ack_mode)
        1:       a = 1'b1;
        2:       a = ((cyc_cnt % 3) == 0);
        3:       a = 1'($urandom_range(0, 1));
        default: a = 1'b0;
      endcase
      wb.ack = a && (expq.size() > 0);
    end
  end

  logic        p_rst   = 1'b1;
  logic        p_en    = 1'b0;
  logic        p_cyc   = 1'b0;
  logic        p_acc   = 1'b0;
  logic        p_bend  = 1'b0;
  logic        p_stall = 1'b0;
  logic [31:0] p_adr   = '0;
  logic [31:0] p_dat   = '0;
  int unsigned burst_n = 0;

  always @(negedge wshb_clk) begin
    logic acc;
    logic bend;
    exp_t e;
    acc  = 1'b0;
    bend = 1'b0;
    if (p_rst) begin
      burst_n = 0;
      chk1("rst_cyc", wb.cyc, 1'b0);
      chk1("rst_stb", wb.stb, 1'b0);
      chk1("rst_frame_done", frame_done, 1'b0);
      chk("rst_adr", wb.adr, 32'h0);
      chk("rst_dat", wb.dat_ms, FG);
    end else begin
      if (p_stall) begin
        chk1("stall_stb", wb.stb, 1'b1);
        chk("stall_adr", wb.adr, p_adr);
        chk("stall_dat", wb.dat_ms, p_dat);
      end
      if (p_acc) chk1("post_ack_cyc", wb.cyc, !(p_bend || !p_en));
      else if (!p_cyc) chk1("restart_cyc", wb.cyc, p_en);
    end
    chk1("stb_eq_cyc", wb.stb, wb.cyc);
    if (wb.stb && wb.ack) begin
      acc = 1'b1;
      n_acc++;
      if (expq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got adr %h required no transfer at %0t", wb.adr, $time);
      end else begin
        e = expq.pop_front();
        chk("adr", wb.adr, e.adr);
        chk("dat", wb.dat_ms, e.dat);
        chk1("frame_done", frame_done, e.fd);
      end
      burst_n++;
      if (burst_n == BURST_LEN) begin
        bend    = 1'b1;
        burst_n = 0;
      end
    end else begin
      chk1("frame_done_idle", frame_done, 1'b0);
    end
    p_rst   = wshb_rst;
    p_en    = enable;
    p_cyc   = wb.cyc;
    p_acc   = acc;
    p_bend  = bend;
    p_stall = wb.stb && !wb.ack;
    p_adr   = wb.adr;
    p_dat   = wb.dat_ms;
  end

  initial begin
    int unsigned n;
    int unsigned sz;

    repeat (3) @(posedge wshb_clk);
    #1 wshb_rst = 1'b0;

    // Full frame plus wrap into the next one, ack held high.
    ack_mode = 1;
    enable   = 1'b1;
    push_expect(NPIX + 2 * BURST_LEN);
    wait_drain("drain_full_frame", 5000);

    // Ack every third cycle.
    ack_mode = 2;
    push_expect(60);
    wait_drain("drain_ack_third", 2000);

    // Random ack, enable dropped mid-burst then restored.
    ack_mode = 3;
    push_expect(40);
    n = 0;
    while (expq.size() > 30 && n < 500) begin
      @(posedge wshb_clk); #1;
      n++;
    end
    enable = 1'b0;
    n = 0;
    while (wb.cyc && n < 200) begin
      @(posedge wshb_clk); #1;
      n++;
    end
    chk1("disable_cyc_drop", wb.cyc, 1'b0);
    sz = expq.size();
    repeat (10) @(posedge wshb_clk);
    #1;
    chk("disabled_no_writes", expq.size(), sz);
    chk1("disabled_cyc", wb.cyc, 1'b0);
    enable = 1'b1;
    wait_drain("drain_reenable", 2000);

    // Reset while a transfer is pending.
    ack_mode = 0;
    push_expect(3);
    n = 0;
    while (!wb.stb && n < 50) begin
      @(posedge wshb_clk); #1;
      n++;
    end
    chk1("stb_before_reset", wb.stb, 1'b1);
    repeat (2) @(posedge wshb_clk);
    #1;
    wshb_rst  = 1'b1;
    n_dropped = n_dropped + expq.size();
    expq.delete();
    next_pix  = 0;
    @(posedge wshb_clk);
    #1 wshb_rst = 1'b0;
    ack_mode = 1;
    push_expect(2 * BURST_LEN + 3);
    wait_drain("drain_after_reset", 2000);

    chk("accept_count", n_acc, n_pushed - n_dropped);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
